// File: rtl/ninjakun_shram_arb.sv
// Shared work-RAM arbiter for the two Ninja-Kun CPUs.
// One RAM cycle at a time; the losing CPU is held in wait until it is served.
module ninjakun_shram_arb #(
    parameter int AW = 11,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          CS0,
    input  logic          WR0,
    input  logic [AW-1:0] AD0,
    input  logic [DW-1:0] DO0,
    output logic [DW-1:0] DI0,
    output logic          WAIT0_N,
    input  logic          CS1,
    input  logic          WR1,
    input  logic [AW-1:0] AD1,
    input  logic [DW-1:0] DO1,
    output logic [DW-1:0] DI1,
    output logic          WAIT1_N,
    output logic [AW-1:0] RAM_AD,
    output logic          RAM_WE,
    output logic [DW-1:0] RAM_DI,
    input  logic [DW-1:0] RAM_DO
);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        CAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic owner;
    logic owner_nx;
    logic last;
    logic done0;
    logic done1;
    logic acc_wr;
    logic pend0;
    logic pend1;
    logic grant;
    logic cs_own;
    logic cap_ok;
    logic cap_rd;

    assign pend0   = CS0 & ~done0;
    assign pend1   = CS1 & ~done1;
    assign WAIT0_N = ~pend0;
    assign WAIT1_N = ~pend1;

    assign cs_own = owner ? CS1 : CS0;
    assign cap_ok = (state == CAP) & cs_own;
    assign cap_rd = cap_ok & ~acc_wr;

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        grant    = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend0 | pend1) begin
                    grant    = 1'b1;
                    state_nx = ACC;
                    // round-robin only matters on a tie
                    if (pend0 & pend1)
                        owner_nx = ~last;
                    else
                        owner_nx = pend1;
                end
            end
            ACC:     state_nx = CAP;
            CAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            owner  <= 1'b0;
            last   <= 1'b1;
            acc_wr <= 1'b0;
            RAM_AD <= '0;
            RAM_WE <= 1'b0;
            RAM_DI <= '0;
        end else begin
            state  <= state_nx;
            owner  <= owner_nx;
            RAM_WE <= 1'b0;
            if (grant) begin
                RAM_AD <= owner_nx ? AD1 : AD0;
                RAM_DI <= owner_nx ? DO1 : DO0;
                RAM_WE <= owner_nx ? WR1 : WR0;
                acc_wr <= owner_nx ? WR1 : WR0;
            end
            if (state == CAP)
                last <= owner;
        end
    end

    // done holds off re-arbitration until CS drops between accesses
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            DI0   <= '0;
            DI1   <= '0;
        end else begin
            if (!CS0)
                done0 <= 1'b0;
            else if (cap_ok && !owner)
                done0 <= 1'b1;
            if (!CS1)
                done1 <= 1'b0;
            else if (cap_ok && owner)
                done1 <= 1'b1;
            if (cap_rd && !owner)
                DI0 <= RAM_DO;
            if (cap_rd && owner)
                DI1 <= RAM_DO;
        end
    end

endmodule
